// File: rtl/vram_arb_pkg.sv
// Shared types and default widths for the vram read arbiter.
package vram_arb_pkg;

    localparam int unsigned VRAM_ADDR_W  = 15;
    localparam int unsigned VRAM_DATA_W  = 13;
    localparam int unsigned STARVE_CNT_W = 8;

    // Owner of an in-flight read in the response pipe.
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_DISP,
        TAG_SPR
    } vram_tag_e;

endpackage

// File: rtl/vram_resp_pipe.sv
// Two-stage tagged response pipe: tags each grant, captures vram data one
// cycle later and presents it with a per-requester valid two cycles after
// the grant.
//   clk, rst_n        : clock, async active-low reset
//   disp_gnt_i        : display granted this cycle
//   spr_gnt_i         : sprite granted this cycle
//   vram_data_i       : vram read data (valid the cycle after the grant)
//   disp_rvalid_o     : display response valid (registered)
//   spr_rvalid_o      : sprite response valid (registered)
//   rdata_o           : response data shared by both requesters (registered)
module vram_resp_pipe
    import vram_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = VRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  disp_gnt_i,
    input  logic                  spr_gnt_i,
    input  logic [DATA_WIDTH-1:0] vram_data_i,
    output logic                  disp_rvalid_o,
    output logic                  spr_rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    vram_tag_e             tag1_d;
    vram_tag_e             tag1_q;
    logic                  disp_rvalid_q;
    logic                  spr_rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Stage-1 tag from this cycle's grant.
    always_comb begin
        tag1_d = TAG_NONE;
        if (disp_gnt_i) begin
            tag1_d = TAG_DISP;
        end else if (spr_gnt_i) begin
            tag1_d = TAG_SPR;
        end
    end

    // Stage 2 keeps the tag as two one-hot valid flops so outputs come
    // straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag1_q        <= TAG_NONE;
            disp_rvalid_q <= 1'b0;
            spr_rvalid_q  <= 1'b0;
            rdata_q       <= '0;
        end else begin
            tag1_q        <= tag1_d;
            disp_rvalid_q <= (tag1_q == TAG_DISP);
            spr_rvalid_q  <= (tag1_q == TAG_SPR);
            if (tag1_q != TAG_NONE) begin
                rdata_q <= vram_data_i;
            end
        end
    end

    assign disp_rvalid_o = disp_rvalid_q;
    assign spr_rvalid_o  = spr_rvalid_q;
    assign rdata_o       = rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Fixed-priority (display first) read arbiter for one synchronous-read vram,
// with a starvation counter that forces a sprite grant after STARVE_LIMIT
// consecutive denied sprite cycles. Responses return two cycles after grant.
//   clk, rst_n                 : clock, async active-low reset
//   disp_req/addr/gnt          : display request, address, grant (comb)
//   disp_rvalid/rdata          : display response (registered)
//   spr_req/addr/gnt           : sprite request, address, grant (comb)
//   spr_rvalid/rdata           : sprite response (registered)
//   vram_addr                  : address driven to vram (comb)
//   vram_data                  : vram read data, one cycle after address
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = VRAM_ADDR_W,
    parameter int unsigned DATA_WIDTH   = VRAM_DATA_W,
    parameter int unsigned STARVE_LIMIT = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_gnt,
    output logic                  disp_rvalid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    input  logic                  spr_req,
    input  logic [ADDR_WIDTH-1:0] spr_addr,
    output logic                  spr_gnt,
    output logic                  spr_rvalid,
    output logic [DATA_WIDTH-1:0] spr_rdata,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    input  logic [DATA_WIDTH-1:0] vram_data
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_cnt_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q;
    logic [ADDR_WIDTH-1:0]   last_addr_d;
    logic [ADDR_WIDTH-1:0]   last_addr_q;
    logic                    spr_force;
    logic [DATA_WIDTH-1:0]   pipe_rdata;

    // Grant selection, vram address mux and starvation counter update.
    // Grants are gated by rst_n so nothing is accepted while in reset.
    always_comb begin
        disp_gnt     = 1'b0;
        spr_gnt      = 1'b0;
        vram_addr    = last_addr_q;
        starve_cnt_d = '0;
        spr_force    = spr_req && (starve_cnt_q == STARVE_MAX);

        if (rst_n) begin
            if (spr_force) begin
                spr_gnt = 1'b1;
            end else if (disp_req) begin
                disp_gnt = 1'b1;
            end else if (spr_req) begin
                spr_gnt = 1'b1;
            end
        end

        if (disp_gnt) begin
            vram_addr = disp_addr;
        end else if (spr_gnt) begin
            vram_addr = spr_addr;
        end
        // Without a grant vram_addr already equals last_addr_q.
        last_addr_d = vram_addr;

        if (spr_req && !spr_gnt) begin
            starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? starve_cnt_q
                                                        : starve_cnt_q + STARVE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            last_addr_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            last_addr_q  <= last_addr_d;
        end
    end

    vram_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_pipe (
        .clk           (clk),
        .rst_n         (rst_n),
        .disp_gnt_i    (disp_gnt),
        .spr_gnt_i     (spr_gnt),
        .vram_data_i   (vram_data),
        .disp_rvalid_o (disp_rvalid),
        .spr_rvalid_o  (spr_rvalid),
        .rdata_o       (pipe_rdata)
    );

    assign disp_rdata = pipe_rdata;
    assign spr_rdata  = pipe_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural
// synchronous-read vram beside it.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int unsigned AW = VRAM_ADDR_W;
    localparam int unsigned DW = VRAM_DATA_W;

    logic          clk;
    logic          rst_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          spr_req;
    logic [AW-1:0] spr_addr;
    logic          spr_gnt;
    logic          spr_rvalid;
    logic [DW-1:0] spr_rdata;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_data;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int tests_run;
    int tests_failed;

    vram_tag_e     etag  [0:31];
    logic [DW-1:0] edata [0:31];

    vram_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .STARVE_LIMIT (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .spr_req     (spr_req),
        .spr_addr    (spr_addr),
        .spr_gnt     (spr_gnt),
        .spr_rvalid  (spr_rvalid),
        .spr_rdata   (spr_rdata),
        .vram_addr   (vram_addr),
        .vram_data   (vram_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read vram model.
    always @(posedge clk) vram_data <= mem[vram_addr];

    // Display must hold its address while waiting for a grant.
    logic          pend_q;
    logic [AW-1:0] pend_addr_q;
    always @(posedge clk) begin
        if (rst_n && pend_q && disp_req && (disp_addr !== pend_addr_q))
            $error("protocol violation: disp_addr changed while waiting for grant");
        pend_q      <= rst_n && disp_req && !disp_gnt;
        pend_addr_q <= disp_addr;
    end

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        if (a == AW'(16'h0010)) return 13'h1ABC;
        return DW'(32'(a) * 7 + 11);
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        disp_req  = 1'b1;
        spr_req   = 1'b1;
        disp_addr = AW'(16'h0055);
        spr_addr  = AW'(16'h0066);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if ({disp_gnt, spr_gnt} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_gnt c=%0d got %b%b exp 00", c, disp_gnt, spr_gnt);
            end
            tests_run++;
            if ({disp_rvalid, spr_rvalid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL reset_rvalid c=%0d got %b%b exp 00", c, disp_rvalid, spr_rvalid);
            end
            tests_run++;
            if (vram_addr !== '0) begin
                tests_failed++;
                $display("FAIL reset_vram_addr c=%0d got %h exp 0", c, vram_addr);
            end
            tests_run++;
            if (disp_rdata !== '0 || spr_rdata !== '0) begin
                tests_failed++;
                $display("FAIL reset_rdata c=%0d got %h/%h exp 0", c, disp_rdata, spr_rdata);
            end
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({disp_gnt, spr_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_release_gnt got %b%b exp 10", disp_gnt, spr_gnt);
        end
        tests_run++;
        if (vram_addr !== AW'(16'h0055)) begin
            tests_failed++;
            $display("FAIL reset_release_addr got %h exp 0055", vram_addr);
        end
        disp_req = 1'b0;
        spr_req  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_disp();
        for (int c = 0; c < 4; c++) begin
            disp_req  = (c == 0);
            disp_addr = AW'(16'h0010);
            spr_req   = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                tests_run++;
                if ({disp_gnt, spr_gnt} !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL single_gnt got %b%b exp 10", disp_gnt, spr_gnt);
                end
            end
            tests_run++;
            if (disp_rvalid !== (c == 2)) begin
                tests_failed++;
                $display("FAIL single_disp_rvalid c=%0d got %b exp %b", c, disp_rvalid, (c == 2));
            end
            tests_run++;
            if (spr_rvalid !== 1'b0) begin
                tests_failed++;
                $display("FAIL single_spr_rvalid c=%0d got %b exp 0", c, spr_rvalid);
            end
            if (c == 2) begin
                tests_run++;
                if (disp_rdata !== 13'h1ABC) begin
                    tests_failed++;
                    $display("FAIL single_rdata got %h exp 1abc", disp_rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] da;
        logic [AW-1:0] sa;
        logic          exp_d;
        logic          exp_s;
        da = AW'(16'h0200);
        sa = AW'(16'h0300);
        for (int c = 0; c < 26; c++) begin
            disp_req  = (c < 24);
            spr_req   = (c < 24);
            disp_addr = da;
            spr_addr  = sa;
            exp_s = (c < 24) && ((c % 8) == 7);
            exp_d = (c < 24) && !exp_s;
            @(negedge clk);
            tests_run++;
            if ({disp_gnt, spr_gnt} !== {exp_d, exp_s}) begin
                tests_failed++;
                $display("FAIL contention_gnt c=%0d got %b%b exp %b%b", c, disp_gnt, spr_gnt, exp_d, exp_s);
            end
            etag[c]  = exp_s ? TAG_SPR : (exp_d ? TAG_DISP : TAG_NONE);
            edata[c] = mem_val(exp_s ? sa : da);
            if (c >= 2) begin
                tests_run++;
                if ({disp_rvalid, spr_rvalid} !== {etag[c-2] == TAG_DISP, etag[c-2] == TAG_SPR}) begin
                    tests_failed++;
                    $display("FAIL contention_rvalid c=%0d got %b%b exp tag %0d", c, disp_rvalid, spr_rvalid, etag[c-2]);
                end
                if (etag[c-2] == TAG_DISP) begin
                    tests_run++;
                    if (disp_rdata !== edata[c-2]) begin
                        tests_failed++;
                        $display("FAIL contention_disp_rdata c=%0d got %h exp %h", c, disp_rdata, edata[c-2]);
                    end
                end
                if (etag[c-2] == TAG_SPR) begin
                    tests_run++;
                    if (spr_rdata !== edata[c-2]) begin
                        tests_failed++;
                        $display("FAIL contention_spr_rdata c=%0d got %h exp %h", c, spr_rdata, edata[c-2]);
                    end
                end
            end
            @(posedge clk); #1;
            if (exp_d) da = da + AW'(1);
            if (exp_s) sa = sa + AW'(1);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] da;
        logic          exp_d;
        logic          exp_s;
        da = '0;
        for (int c = 0; c < 11; c++) begin
            disp_req  = (c <= 8);
            spr_req   = (c <= 7);
            disp_addr = da;
            spr_addr  = AW'(100);
            exp_s = (c == 7);
            exp_d = (c <= 8) && !exp_s;
            @(negedge clk);
            tests_run++;
            if ({disp_gnt, spr_gnt} !== {exp_d, exp_s}) begin
                tests_failed++;
                $display("FAIL b2b_gnt c=%0d got %b%b exp %b%b", c, disp_gnt, spr_gnt, exp_d, exp_s);
            end
            etag[c]  = exp_s ? TAG_SPR : (exp_d ? TAG_DISP : TAG_NONE);
            edata[c] = mem_val(exp_s ? AW'(100) : da);
            if (c >= 2) begin
                tests_run++;
                if ((disp_rvalid | spr_rvalid) !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b_bubble c=%0d got %b%b exp one valid", c, disp_rvalid, spr_rvalid);
                end
                tests_run++;
                if ({disp_rvalid, spr_rvalid} !== {etag[c-2] == TAG_DISP, etag[c-2] == TAG_SPR}) begin
                    tests_failed++;
                    $display("FAIL b2b_tag c=%0d got %b%b exp tag %0d", c, disp_rvalid, spr_rvalid, etag[c-2]);
                end
                tests_run++;
                if (disp_rdata !== edata[c-2]) begin
                    tests_failed++;
                    $display("FAIL b2b_rdata c=%0d got %h exp %h", c, disp_rdata, edata[c-2]);
                end
            end
            @(posedge clk); #1;
            if (exp_d) da = da + AW'(1);
        end
    endtask

    task automatic test_idle_hold();
        for (int c = 0; c < 6; c++) begin
            disp_req  = (c == 0);
            disp_addr = (c == 0) ? AW'(16'h7FFF) : AW'(16'h1234);
            spr_req   = 1'b0;
            @(negedge clk);
            tests_run++;
            if (disp_gnt !== (c == 0)) begin
                tests_failed++;
                $display("FAIL idle_gnt c=%0d got %b exp %b", c, disp_gnt, (c == 0));
            end
            tests_run++;
            if (vram_addr !== AW'(16'h7FFF)) begin
                tests_failed++;
                $display("FAIL idle_vram_addr c=%0d got %h exp 7fff", c, vram_addr);
            end
            tests_run++;
            if ({disp_rvalid, spr_rvalid} !== {(c == 2), 1'b0}) begin
                tests_failed++;
                $display("FAIL idle_rvalid c=%0d got %b%b exp %b0", c, disp_rvalid, spr_rvalid, (c == 2));
            end
            if (c == 2) begin
                tests_run++;
                if (disp_rdata !== mem_val(AW'(16'h7FFF))) begin
                    tests_failed++;
                    $display("FAIL idle_rdata got %h exp %h", disp_rdata, mem_val(AW'(16'h7FFF)));
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midflight();
        logic [AW-1:0] da;
        logic          exp_s;
        disp_req  = 1'b1;
        disp_addr = AW'(16'h0020);
        spr_req   = 1'b0;
        @(negedge clk);
        tests_run++;
        if (disp_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_gnt got %b exp 1", disp_gnt);
        end
        @(posedge clk); #1;
        rst_n     = 1'b0;
        spr_req   = 1'b1;
        spr_addr  = AW'(16'h0500);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if ({disp_gnt, spr_gnt, disp_rvalid, spr_rvalid} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL midrst_in_reset c=%0d got %b%b%b%b exp 0000", c, disp_gnt, spr_gnt, disp_rvalid, spr_rvalid);
            end
            tests_run++;
            if (vram_addr !== '0) begin
                tests_failed++;
                $display("FAIL midrst_vram_addr c=%0d got %h exp 0", c, vram_addr);
            end
            if (c == 0) begin
                @(posedge clk); #1;
            end
        end
        rst_n    = 1'b1;
        disp_req = 1'b0;
        spr_req  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            tests_run++;
            if ({disp_rvalid, spr_rvalid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL midrst_ghost c=%0d got %b%b exp 00", c, disp_rvalid, spr_rvalid);
            end
        end
        @(posedge clk); #1;
        da = AW'(16'h0400);
        for (int c = 0; c < 9; c++) begin
            disp_req  = 1'b1;
            spr_req   = (c <= 7);
            disp_addr = da;
            exp_s = (c == 7);
            @(negedge clk);
            tests_run++;
            if ({disp_gnt, spr_gnt} !== {!exp_s, exp_s}) begin
                tests_failed++;
                $display("FAIL midrst_starve c=%0d got %b%b exp %b%b", c, disp_gnt, spr_gnt, !exp_s, exp_s);
            end
            @(posedge clk); #1;
            if (!exp_s) da = da + AW'(1);
        end
        disp_req = 1'b0;
        spr_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        disp_req     = 1'b0;
        spr_req      = 1'b0;
        disp_addr    = '0;
        spr_addr     = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = mem_val(AW'(i));

        test_reset();
        test_single_disp();
        test_contention();
        test_back_to_back();
        test_idle_hold();
        test_reset_midflight();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
